// File: rtl/exu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : exu_issue_ctrl
// Description : Issue/retire sequencer for the single shared EXU datapath.
//               Accepts one decoded op from IDU (valid/ready), holds it on the
//               EXU inputs for LAT cycles, captures the EXU result and offers
//               it to WBU (valid/ready) until accepted. One op in flight.
//
// Parameters  : DATAWIDTH - operand/result width
//               LAT       - EXU evaluation cycles per op (1..15)
//
// Ports       : clk, rst (async, active-high), flush (sync abort)
//               in_valid/in_ready, in_rdata1, in_rdata2, in_imm, in_mode,
//               in_rd                      - op from IDU
//               exu_rdata1, exu_rdata2, exu_imm, exu_mode - held op to EXU
//               exu_data                   - result from EXU
//               out_valid/out_ready, out_data, out_rd, out_err - to WBU
//               perf_issued, perf_stall    - only with EXU_PERF_EN
//
// Config      : EXU_PERF_EN - when defined, adds the performance counters
//               perf_issued (accepted ops) and perf_stall (DONE cycles
//               waiting on WBU). Both wrap and freeze during flush.
//
// Revision    : 1.0 - initial release
// ============================================================================
module exu_issue_ctrl #(
    parameter int DATAWIDTH = 32,
    parameter int LAT       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_rdata1,
    input  logic [DATAWIDTH-1:0] in_rdata2,
    input  logic [DATAWIDTH-1:0] in_imm,
    input  logic [3:0]           in_mode,
    input  logic [4:0]           in_rd,
    output logic [DATAWIDTH-1:0] exu_rdata1,
    output logic [DATAWIDTH-1:0] exu_rdata2,
    output logic [DATAWIDTH-1:0] exu_imm,
    output logic [3:0]           exu_mode,
    input  logic [DATAWIDTH-1:0] exu_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [4:0]           out_rd,
    output logic                 out_err
`ifdef EXU_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    localparam int                CNT_W      = 4;
    localparam int unsigned       c_LAT_M1   = LAT - 1;
    localparam logic [CNT_W-1:0]  c_CNT_INIT = c_LAT_M1[CNT_W-1:0];

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // EXU mode encodings that the datapath actually implements
    localparam logic [3:0] c_MODE_ADD_RR = 4'b0000;
    localparam logic [3:0] c_MODE_ADD_RI = 4'b0001;
    localparam logic [3:0] c_MODE_UCMP   = 4'b0100;
    localparam logic [3:0] c_MODE_SCMP   = 4'b1000;

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATAWIDTH-1:0] r_rdata1;
    logic [DATAWIDTH-1:0] r_rdata2;
    logic [DATAWIDTH-1:0] r_imm;
    logic [3:0]           r_mode;
    logic [4:0]           r_rd;
    logic                 r_out_valid;
    logic [DATAWIDTH-1:0] r_out_data;
    logic [4:0]           r_out_rd;
    logic                 r_out_err;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_mode_legal;

    // DONE reuses the WBU handshake as the IDU ready so a new op can be
    // loaded on the very edge the old result retires (no bubble). A flush
    // cycle never accepts.
    always_comb begin
        w_in_ready = 1'b0;
        if (!flush) begin
            case (r_state)
                c_ST_IDLE: w_in_ready = 1'b1;
                c_ST_DONE: w_in_ready = out_ready;
                default:   w_in_ready = 1'b0;
            endcase
        end
    end

    assign w_accept     = in_valid & w_in_ready;
    assign w_mode_legal = (r_mode == c_MODE_ADD_RR) || (r_mode == c_MODE_ADD_RI) ||
                          (r_mode == c_MODE_UCMP)   || (r_mode == c_MODE_SCMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_rdata1    <= '0;
            r_rdata2    <= '0;
            r_imm       <= '0;
            r_mode      <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_rd    <= '0;
            r_out_err   <= 1'b0;
        end else if (flush) begin
            // Abort: op registers and last result are left as they are.
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Op capture is shared by IDLE and the DONE reload path.
            if (w_accept) begin
                r_rdata1 <= in_rdata1;
                r_rdata2 <= in_rdata2;
                r_imm    <= in_imm;
                r_mode   <= in_mode;
                r_rd     <= in_rd;
                r_cnt    <= c_CNT_INIT;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        // Illegal modes are still issued; EXU output is
                        // forwarded as-is and only flagged.
                        r_out_data  <= exu_data;
                        r_out_rd    <= r_rd;
                        r_out_err   <= ~w_mode_legal;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= in_valid ? c_ST_EXEC : c_ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXU_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else if (!flush) begin
            if (w_accept) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if ((r_state == c_ST_DONE) && !out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif

    assign in_ready   = w_in_ready;
    assign exu_rdata1 = r_rdata1;
    assign exu_rdata2 = r_rdata2;
    assign exu_imm    = r_imm;
    assign exu_mode   = r_mode;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_rd     = r_out_rd;
    assign out_err    = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_exu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_exu_issue_ctrl
// Description : Self-checking bench for exu_issue_ctrl. A behavioural EXU
//               drives exu_data; a scoreboard queue holds accepted ops and
//               a negedge monitor compares state, handshakes and results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_issue_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_rdata1 = '0, in_rdata2 = '0, in_imm = '0;
    logic [3:0]    in_mode = '0;
    logic [4:0]    in_rd = '0;
    logic [DW-1:0] exu_rdata1, exu_rdata2, exu_imm;
    logic [3:0]    exu_mode;
    logic [DW-1:0] exu_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [4:0]    out_rd;
    logic          out_err;
`ifdef EXU_PERF_EN
    logic [31:0]   perf_issued, perf_stall;
`endif

    exu_issue_ctrl #(.DATAWIDTH(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
        .in_mode(in_mode), .in_rd(in_rd),
        .exu_rdata1(exu_rdata1), .exu_rdata2(exu_rdata2), .exu_imm(exu_imm),
        .exu_mode(exu_mode), .exu_data(exu_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_err(out_err)
`ifdef EXU_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural EXU: add, add-imm, and compares returning {lt,eq,gt}.
    function automatic logic [DW-1:0] exu_fn(logic [DW-1:0] a, logic [DW-1:0] b,
                                              logic [DW-1:0] imm, logic [3:0] mode);
        case (mode)
            4'b0000: return a + b;
            4'b0001: return a + imm;
            4'b0100: return {29'd0, a < b, a == b, a > b};
            4'b1000: return {29'd0, $signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
            default: return '0;
        endcase
    endfunction

    assign exu_data = exu_fn(exu_rdata1, exu_rdata2, exu_imm, exu_mode);

    typedef struct {
        logic [DW-1:0] a, b, imm, data;
        logic [3:0]    mode;
        logic [4:0]    rd;
        logic          err;
        int            done_edge;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    m_issued = 0;
    int    m_stall = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: model state comes from the queue head and its due edge.
    always @(negedge clk) begin
        if (!rst) begin
            bit idle, done, exp_rdy;
            item_t it;
            idle    = (sb.size() == 0);
            done    = !idle && (cyc >= sb[0].done_edge);
            exp_rdy = !flush && (idle || (done && out_ready));
            chk("out_valid", 32'(out_valid), 32'(done));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (done) begin
                chk("out_data", out_data, sb[0].data);
                chk("out_rd", 32'(out_rd), 32'(sb[0].rd));
                chk("out_err", 32'(out_err), 32'(sb[0].err));
            end else if (!idle) begin
                chk("exu_rdata1", exu_rdata1, sb[0].a);
                chk("exu_rdata2", exu_rdata2, sb[0].b);
                chk("exu_imm", exu_imm, sb[0].imm);
                chk("exu_mode", 32'(exu_mode), 32'(sb[0].mode));
            end
`ifdef EXU_PERF_EN
            chk("perf_issued", perf_issued, 32'(m_issued));
            chk("perf_stall", perf_stall, 32'(m_stall));
`endif
            if (flush) begin
                sb.delete();
            end else begin
                if (done && !out_ready) m_stall = m_stall + 1;
                if (done && out_ready) void'(sb.pop_front());
                if (in_valid && exp_rdy) begin
                    it.a = in_rdata1; it.b = in_rdata2; it.imm = in_imm;
                    it.mode = in_mode; it.rd = in_rd;
                    it.data = exu_fn(in_rdata1, in_rdata2, in_imm, in_mode);
                    it.err  = !(in_mode inside {4'b0000, 4'b0001, 4'b0100, 4'b1000});
                    it.done_edge = cyc + 1 + LAT;
                    sb.push_back(it);
                    m_issued = m_issued + 1;
                end
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(bit v, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                         logic [3:0] mode, logic [4:0] rd, bit ordy, bit fl);
        @(posedge clk);
        #1;
        in_valid = v; in_rdata1 = a; in_rdata2 = b; in_imm = imm;
        in_mode = mode; in_rd = rd; out_ready = ordy; flush = fl;
    endtask

    task automatic idle_cycles(int n, bit ordy);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, '0, ordy, 1'b0);
    endtask

    initial begin
        bit got;
        logic [3:0] m;
        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst out_rd", 32'(out_rd), 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        chk("rst exu_rdata1", exu_rdata1, 32'd0);
        chk("rst exu_mode", 32'(exu_mode), 32'd0);
        rst = 1'b0;

        // add rr 5+7
        drive(1'b1, 32'd5, 32'd7, 32'd0, 4'b0000, 5'd3, 1'b1, 1'b0);
        idle_cycles(LAT + 2, 1'b1);
        // ucmp 3 vs 9 -> lt flag
        drive(1'b1, 32'd3, 32'd9, 32'd0, 4'b0100, 5'd9, 1'b1, 1'b0);
        idle_cycles(LAT + 2, 1'b1);
        // WBU stall then back-to-back reload
        drive(1'b1, 32'd100, 32'd0, 32'd23, 4'b0001, 5'd4, 1'b0, 1'b0);
        idle_cycles(LAT + 3, 1'b0);
        drive(1'b1, 32'hFFFF_FFFE, 32'd1, 32'd0, 4'b1000, 5'd0, 1'b1, 1'b0);
        idle_cycles(LAT + 2, 1'b1);
        // illegal mode
        drive(1'b1, 32'd11, 32'd12, 32'd13, 4'b0010, 5'd31, 1'b1, 1'b0);
        idle_cycles(LAT + 2, 1'b1);
        // flush during the second EXEC cycle
        drive(1'b1, 32'd1, 32'd2, 32'd0, 4'b0000, 5'd5, 1'b1, 1'b0);
        idle_cycles(1, 1'b1);
        drive(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b1);
        idle_cycles(LAT + 2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: m = 4'b0000;
                1: m = 4'b0001;
                2: m = 4'b0100;
                3: m = 4'b1000;
                default: m = 4'($urandom_range(0, 15));
            endcase
            drive($urandom_range(0, 2) != 0, $urandom, ($urandom_range(0, 3) == 0) ? in_rdata1 : $urandom,
                  $urandom, m, 5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
        end
        idle_cycles(LAT + 3, 1'b1);

        // Async reset in the middle of DONE
        drive(1'b1, 32'd40, 32'd2, 32'd0, 4'b0000, 5'd7, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            idle_cycles(1, 1'b0);
            got = out_valid;
        end
        chk("reach DONE before async reset", 32'(got), 32'd1);
        #1;
        rst = 1'b1;
        sb.delete();
        m_issued = 0;
        m_stall  = 0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_data", out_data, 32'd0);
        chk("async rst out_rd", 32'(out_rd), 32'd0);
        #1;
        rst = 1'b0;
        #0;
        chk("in_ready after rst release", 32'(in_ready), 32'd1);
        idle_cycles(2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
